// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle signed divider sequencer for the MiniSRC datapath.
// Restoring shift-subtract, one quotient bit per clock; quotient -> LO, remainder -> HI.
// Results follow signed truncating division: quotient rounds toward zero,
// remainder carries the sign of the dividend.
module div_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_cap;     // captured dividend
  logic [WIDTH-1:0] b_cap;     // captured divisor
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] dq;        // |dividend| shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs;       // |divisor|
  logic [WIDTH:0]   pr;        // partial remainder, one spare bit for the shift
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    shifted = {pr[WIDTH-1:0], dq[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    ge      = (shifted >= {1'b0, dvs});
  end

  // Sequencer: capture, magnitude prep, WIDTH iterations, sign fix-up, done pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      a_cap       <= '0;
      b_cap       <= '0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      dq          <= '0;
      dvs         <= '0;
      pr          <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_cap       <= dividend;
            b_cap       <= divisor;
            a_neg       <= dividend[WIDTH-1];
            b_neg       <= divisor[WIDTH-1];
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= S_PREP;
          end
        end
        S_PREP: begin
          // Magnitudes as unsigned; the most negative value maps onto itself.
          dq    <= a_neg ? (~a_cap + WIDTH'(1)) : a_cap;
          dvs   <= b_neg ? (~b_cap + WIDTH'(1)) : b_cap;
          pr    <= '0;
          cnt   <= CW'(WIDTH - 1);
          state <= S_ITER;
        end
        S_ITER: begin
          if (ge) begin
            pr <= diff;
            dq <= {dq[WIDTH-2:0], 1'b1};
          end else begin
            pr <= shifted;
            dq <= {dq[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (b_cap == '0) begin
            quotient    <= '0;
            remainder   <= a_cap;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= (a_neg ^ b_neg) ? (~dq + WIDTH'(1)) : dq;
            remainder   <= a_neg ? (~pr[WIDTH-1:0] + WIDTH'(1)) : pr[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed and randomized checks of div_seq_ctrl against
// a 64-bit integer reference of signed truncating division.
module tb_div_seq_ctrl;

  localparam int unsigned W = 32;

  logic         clk;
  logic         clr;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed division in 64 bits, wrapped back to W bits.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = '0;
      r = a;
      z = 1'b1;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end
  endtask

  // One full operation with handshake, latency and result checks.
  task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int cnt;
    bit busy_ok;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check({tag, " busy@E0"}, 64'(busy), 64'(1));
    check({tag, " dz@E0"}, 64'(div_by_zero), 64'(0));
    cnt     = 0;
    busy_ok = 1'b1;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 64'(cnt), 64'(W + 2));
    check({tag, " busy held"}, 64'(busy_ok), 64'(1));
    check({tag, " quotient"}, 64'(quotient), 64'(eq));
    check({tag, " remainder"}, 64'(remainder), 64'(er));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    @(negedge clk);
    check({tag, " done pulse"}, 64'({done, busy}), 64'(0));
    check({tag, " q hold"}, 64'(quotient), 64'(eq));
  endtask

  initial begin : stim
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    logic [W-1:0] q_seen;
    logic [W-1:0] r_seen;
    logic [W-1:0] edge_vals [4];
    int           n_done;

    edge_vals[0] = 32'h8000_0000;
    edge_vals[1] = 32'hFFFF_FFFF;
    edge_vals[2] = 32'h0000_0001;
    edge_vals[3] = 32'h7FFF_FFFF;
    q_seen       = '0;
    r_seen       = '0;

    clr      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    check("reset outputs", {busy, done, div_by_zero, quotient, remainder}, 64'(0));
    @(negedge clk);
    clr = 1'b0;

    // Directed sign and boundary cases.
    do_div("100/7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    do_div("-100/7",  W'(-100),       32'd7,          W'(-14),        W'(-2),         1'b0);
    do_div("7/-100",  32'd7,          W'(-100),       32'd0,          32'd7,          1'b0);
    do_div("-7/-2",   W'(-7),         W'(-2),         32'd3,          W'(-1),         1'b0);
    do_div("min/-1",  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    do_div("max/1",   32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0);
    do_div("5/0",     32'd5,          32'd0,          32'd0,          32'd5,          1'b1);
    do_div("9/3",     32'd9,          32'd3,          32'd3,          32'd0,          1'b0);

    // start held through ITER with changing operands, re-asserted during DONE.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd7;
    start    = 1'b1;
    n_done   = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i < 10) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      if (i == 10) start = 1'b0;
      if (done) begin
        n_done++;
        q_seen = quotient;
        r_seen = remainder;
        start  = 1'b1;
      end else if (n_done > 0) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("held start done count", 64'(n_done), 64'(1));
    check("held start quotient", 64'(q_seen), 64'(142));
    check("held start remainder", 64'(r_seen), 64'(6));
    check("held start idle", 64'(busy), 64'(0));

    // Asynchronous clear in the middle of an operation.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    #1;
    check("mid clear outputs", {busy, done, div_by_zero, quotient, remainder}, 64'(0));
    @(negedge clk);
    clr    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("no done after clear", 64'(n_done), 64'(0));
    do_div("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    // Randomized pairs with nonzero divisors.
    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(7) == 0) ? edge_vals[$urandom_range(3)] : W'($urandom);
      case ($urandom_range(3))
        0:       b = edge_vals[$urandom_range(3)];
        1:       b = W'($urandom_range(255));
        2:       b = W'(-$urandom_range(255));
        default: b = W'($urandom);
      endcase
      if (b == '0) b = 32'd1;
      model(a, b, eq, er, ez);
      do_div("random", a, b, eq, er, ez);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
